// File: rtl/x_uart_tx_buf.sv
// x_uart_tx_buf: buffered 8N1 UART transmitter.
// Bytes enter a small FIFO through a valid/accept handshake and are
// serialised LSB-first on o_tx. Define X_UART_TX_PARITY_EN to insert an
// even-parity bit between the data bits and the stop bit.
module x_uart_tx_buf #(
  parameter int unsigned p_clk_hz = 50000000,
  parameter int unsigned p_baud   = 115200,
  parameter int unsigned p_depth  = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  input  logic [7:0]                   i_data,
  output logic                         o_accept,
  output logic                         o_tx,
  output logic                         o_busy,
  output logic [$clog2(p_depth+1)-1:0] o_level
);

  localparam int unsigned BIT = p_clk_hz / p_baud;
  localparam int unsigned CW  = $clog2(BIT);
  localparam int unsigned AW  = $clog2(p_depth);
  localparam int unsigned LW  = $clog2(p_depth + 1);
  localparam logic [CW-1:0] RELOAD = CW'(BIT - 1);

`ifdef X_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW:0]   wptr_q, rptr_q;
  logic [7:0]    mem_q [p_depth];
`ifdef X_UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic [AW:0] level;
  logic        full, empty, push, load, cnt_last, tx;
  logic [7:0]  head;

  assign level    = wptr_q - rptr_q;
  assign full     = (level == (AW+1)'(p_depth));
  assign empty    = (wptr_q == rptr_q);
  assign push     = i_valid && !full;
  assign head     = mem_q[rptr_q[AW-1:0]];
  assign cnt_last = (cnt_q == '0);

  assign o_accept = !full;
  assign o_level  = LW'(level);
  assign o_busy   = (state_q != S_IDLE) || !empty;
  assign o_tx     = tx;

  // FIFO storage: written on every accepted push, never reset.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= i_data;
  end

  // FIFO pointers; a pop is the FSM loading a new frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (load) rptr_q <= rptr_q + 1'b1;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef X_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef X_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next state, baud timing and line level.
  // IDLE and the last STOP cycle share one load path so back-to-back
  // frames start with no idle gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    load    = 1'b0;
    tx      = 1'b1;
`ifdef X_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE) cnt_d = cnt_last ? RELOAD : cnt_q - 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!empty) load = 1'b1;
      end
      S_START: begin
        tx = 1'b0;
        if (cnt_last) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        tx = shift_q[0];
        if (cnt_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
`ifdef X_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef X_UART_TX_PARITY_EN
      S_PARITY: begin
        tx = par_q;
        if (cnt_last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (cnt_last) begin
          if (!empty) load = 1'b1;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d = S_START;
      shift_d = head;
      cnt_d   = RELOAD;
`ifdef X_UART_TX_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

endmodule
